// File: rtl/sccb_config_master_if.sv
// Bundles the ROM read port, the SCCB pads and run control/status of the
// SCCB configuration master.
interface sccb_config_master_if #(
  parameter int ROM_ADDR_W = 8
);
  logic                  start;
  logic [ROM_ADDR_W-1:0] rom_addr;
  logic [15:0]           rom_data;
  logic                  scl_o;
  logic                  sda_oe;
  logic                  sda_i;
  logic                  busy;
  logic                  done;
  logic                  nack_err;
  logic [ROM_ADDR_W-1:0] write_count;

  modport master (
    input  start, rom_data, sda_i,
    output rom_addr, scl_o, sda_oe, busy, done, nack_err, write_count
  );

  modport slave (
    output start, rom_data, sda_i,
    input  rom_addr, scl_o, sda_oe, busy, done, nack_err, write_count
  );
endinterface

// File: rtl/sccb_config_master.sv
// SCCB (I2C-compatible) write master: walks a ROM register table and issues a
// 3-byte write (device ID, register address, data) per entry.
module sccb_config_master #(
  parameter int          CLK_DIV      = 250,
  parameter logic [7:0]  DEV_ADDR     = 8'h42,
  parameter int          ROM_ADDR_W   = 8,
  parameter logic [15:0] END_MARKER   = 16'hFFFF,
  parameter logic [15:0] DELAY_MARKER = 16'hFFF0,
  parameter int          DELAY_CYCLES = 1_000_000,
  parameter bit          ACK_CHECK    = 1'b1
) (
  input  logic                 clk,
  input  logic                 reset,
  sccb_config_master_if.master bus
);
  localparam int DIV_W = $clog2(CLK_DIV);
  localparam int DLY_W = $clog2(DELAY_CYCLES + 1);
  localparam logic [DIV_W-1:0]      DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [DLY_W-1:0]      DLY_LAST  = DLY_W'(DELAY_CYCLES - 1);
  localparam logic [ROM_ADDR_W-1:0] ADDR_LAST = {ROM_ADDR_W{1'b1}};

  typedef enum logic [3:0] {
    S_IDLE  = 4'd0, S_FETCH = 4'd1, S_DECODE = 4'd2, S_DELAY = 4'd3,
    S_START = 4'd4, S_BIT   = 4'd5, S_ACK    = 4'd6, S_STOP  = 4'd7,
    S_GAP   = 4'd8, S_DONE  = 4'd9, S_ERROR  = 4'd10
  } state_t;

  state_t                state_r, state_s;
  logic [DIV_W-1:0]      div_r, div_s;
  logic [1:0]            qtr_r, qtr_s;
  logic [2:0]            bit_r, bit_s;
  logic [1:0]            byte_r, byte_s;
  logic [DLY_W-1:0]      dly_r, dly_s;
  logic [7:0]            reg_addr_r, reg_addr_s, reg_data_r, reg_data_s, tx_byte_s;
  logic [ROM_ADDR_W-1:0] rom_addr_r, rom_addr_s, write_count_r, write_count_s;
  logic                  nack_err_r, nack_err_s, busy_r, busy_s, done_r, done_s;
  logic                  scl_r, scl_s, sda_oe_r, sda_oe_s;
  logic                  on_bus_s, tick_s;

  assign on_bus_s = state_r inside {S_START, S_BIT, S_ACK, S_STOP, S_GAP};
  assign tick_s   = on_bus_s && (div_r == DIV_LAST);

  // Next-state and datapath updates; bus phases only advance on quarter ticks.
  always_comb begin
    state_s       = state_r;
    qtr_s         = qtr_r;
    bit_s         = bit_r;
    byte_s        = byte_r;
    dly_s         = dly_r;
    reg_addr_s    = reg_addr_r;
    reg_data_s    = reg_data_r;
    rom_addr_s    = rom_addr_r;
    write_count_s = write_count_r;
    nack_err_s    = nack_err_r;
    if (on_bus_s && !tick_s) begin
      div_s = div_r + 1'b1;
    end else begin
      div_s = {DIV_W{1'b0}};
    end
    case (state_r)
      S_IDLE: begin
        if (bus.start) begin
          rom_addr_s    = {ROM_ADDR_W{1'b0}};
          write_count_s = {ROM_ADDR_W{1'b0}};
          nack_err_s    = 1'b0;
          state_s       = S_FETCH;
        end else begin
          state_s = S_IDLE;
        end
      end
      S_FETCH: state_s = S_DECODE;
      S_DECODE: begin
        if (bus.rom_data == END_MARKER) begin
          state_s = S_DONE;
        end else if (bus.rom_data == DELAY_MARKER) begin
          dly_s   = {DLY_W{1'b0}};
          state_s = S_DELAY;
        end else begin
          reg_addr_s = bus.rom_data[15:8];
          reg_data_s = bus.rom_data[7:0];
          byte_s     = 2'd0;
          bit_s      = 3'd7;
          qtr_s      = 2'd0;
          state_s    = S_START;
        end
      end
      S_DELAY: begin
        if (dly_r != DLY_LAST) begin
          dly_s = dly_r + 1'b1;
        end else if (rom_addr_r == ADDR_LAST) begin
          state_s = S_DONE;
        end else begin
          rom_addr_s = rom_addr_r + 1'b1;
          state_s    = S_FETCH;
        end
      end
      S_START: begin
        if (!tick_s) begin
          qtr_s = qtr_r;
        end else if (qtr_r == 2'd1) begin
          qtr_s   = 2'd0;
          bit_s   = 3'd7;
          state_s = S_BIT;
        end else begin
          qtr_s = qtr_r + 2'd1;
        end
      end
      S_BIT: begin
        if (!tick_s) begin
          qtr_s = qtr_r;
        end else if (qtr_r != 2'd3) begin
          qtr_s = qtr_r + 2'd1;
        end else if (bit_r == 3'd0) begin
          qtr_s   = 2'd0;
          state_s = S_ACK;
        end else begin
          qtr_s = 2'd0;
          bit_s = bit_r - 3'd1;
        end
      end
      S_ACK: begin
        // A NACK is latched at the end of Q2; the ACK clock still completes.
        if (!tick_s) begin
          qtr_s = qtr_r;
        end else if (qtr_r == 2'd2) begin
          qtr_s = 2'd3;
          if (ACK_CHECK && bus.sda_i) begin
            nack_err_s = 1'b1;
          end else begin
            nack_err_s = nack_err_r;
          end
        end else if (qtr_r != 2'd3) begin
          qtr_s = qtr_r + 2'd1;
        end else if (nack_err_r || (byte_r == 2'd2)) begin
          qtr_s   = 2'd0;
          state_s = S_STOP;
        end else begin
          qtr_s   = 2'd0;
          bit_s   = 3'd7;
          byte_s  = byte_r + 2'd1;
          state_s = S_BIT;
        end
      end
      S_STOP: begin
        if (!tick_s) begin
          qtr_s = qtr_r;
        end else if (qtr_r == 2'd2) begin
          qtr_s   = 2'd0;
          state_s = nack_err_r ? S_ERROR : S_GAP;
        end else begin
          qtr_s = qtr_r + 2'd1;
        end
      end
      S_GAP: begin
        if (!tick_s) begin
          qtr_s = qtr_r;
        end else if (qtr_r != 2'd3) begin
          qtr_s = qtr_r + 2'd1;
        end else if (rom_addr_r == ADDR_LAST) begin
          qtr_s         = 2'd0;
          write_count_s = write_count_r + 1'b1;
          state_s       = S_DONE;
        end else begin
          qtr_s         = 2'd0;
          write_count_s = write_count_r + 1'b1;
          rom_addr_s    = rom_addr_r + 1'b1;
          state_s       = S_FETCH;
        end
      end
      S_DONE:  state_s = S_IDLE;
      S_ERROR: state_s = S_IDLE;
      default: state_s = S_IDLE;
    endcase
  end

  // Pad levels and status derived from the next state so outputs are registered.
  always_comb begin
    scl_s    = 1'b1;
    sda_oe_s = 1'b0;
    case (byte_s)
      2'd0:    tx_byte_s = DEV_ADDR;
      2'd1:    tx_byte_s = reg_addr_s;
      default: tx_byte_s = reg_data_s;
    endcase
    case (state_s)
      S_START: sda_oe_s = (qtr_s == 2'd1);
      S_BIT: begin
        scl_s    = qtr_s[1];
        sda_oe_s = ~tx_byte_s[bit_s];
      end
      S_ACK:   scl_s = qtr_s[1];
      S_STOP: begin
        scl_s    = (qtr_s != 2'd0);
        sda_oe_s = (qtr_s != 2'd2);
      end
      default: begin
        scl_s    = 1'b1;
        sda_oe_s = 1'b0;
      end
    endcase
    busy_s = state_s inside {S_FETCH, S_DECODE, S_DELAY, S_START, S_BIT,
                             S_ACK, S_STOP, S_GAP};
    done_s = (state_s == S_DONE);
  end

  // State and output registers; reset releases the bus immediately.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= S_IDLE;
      div_r         <= {DIV_W{1'b0}};
      qtr_r         <= 2'd0;
      bit_r         <= 3'd0;
      byte_r        <= 2'd0;
      dly_r         <= {DLY_W{1'b0}};
      reg_addr_r    <= 8'd0;
      reg_data_r    <= 8'd0;
      rom_addr_r    <= {ROM_ADDR_W{1'b0}};
      write_count_r <= {ROM_ADDR_W{1'b0}};
      nack_err_r    <= 1'b0;
      busy_r        <= 1'b0;
      done_r        <= 1'b0;
      scl_r         <= 1'b1;
      sda_oe_r      <= 1'b0;
    end else begin
      state_r       <= state_s;
      div_r         <= div_s;
      qtr_r         <= qtr_s;
      bit_r         <= bit_s;
      byte_r        <= byte_s;
      dly_r         <= dly_s;
      reg_addr_r    <= reg_addr_s;
      reg_data_r    <= reg_data_s;
      rom_addr_r    <= rom_addr_s;
      write_count_r <= write_count_s;
      nack_err_r    <= nack_err_s;
      busy_r        <= busy_s;
      done_r        <= done_s;
      scl_r         <= scl_s;
      sda_oe_r      <= sda_oe_s;
    end
  end

  assign bus.rom_addr    = rom_addr_r;
  assign bus.scl_o       = scl_r;
  assign bus.sda_oe      = sda_oe_r;
  assign bus.busy        = busy_r;
  assign bus.done        = done_r;
  assign bus.nack_err    = nack_err_r;
  assign bus.write_count = write_count_r;
endmodule

// File: tb/tb_sccb_config_master.sv
// Bench for sccb_config_master: ROM model, SCCB slave/bus decoder and a
// table-walk reference model; three DUT builds share one decoder via a mux.
`timescale 1ns/1ps
module tb_sccb_config_master;
  localparam int          CLK_DIV = 4;
  localparam int          DLY     = 100;
  localparam logic [7:0]  DEV     = 8'h42;
  localparam logic [15:0] END_W   = 16'hFFFF;
  localparam logic [15:0] DLY_WD  = 16'hFFF0;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  sccb_config_master_if #(.ROM_ADDR_W(8)) b0 ();
  sccb_config_master_if #(.ROM_ADDR_W(8)) b1 ();
  sccb_config_master_if #(.ROM_ADDR_W(2)) b2 ();

  sccb_config_master #(.CLK_DIV(CLK_DIV), .DEV_ADDR(DEV), .ROM_ADDR_W(8), .END_MARKER(END_W),
    .DELAY_MARKER(DLY_WD), .DELAY_CYCLES(DLY), .ACK_CHECK(1'b1)) u0 (.clk(clk), .reset(reset), .bus(b0));
  sccb_config_master #(.CLK_DIV(CLK_DIV), .DEV_ADDR(DEV), .ROM_ADDR_W(8), .END_MARKER(END_W),
    .DELAY_MARKER(DLY_WD), .DELAY_CYCLES(DLY), .ACK_CHECK(1'b0)) u1 (.clk(clk), .reset(reset), .bus(b1));
  sccb_config_master #(.CLK_DIV(CLK_DIV), .DEV_ADDR(DEV), .ROM_ADDR_W(2), .END_MARKER(END_W),
    .DELAY_MARKER(DLY_WD), .DELAY_CYCLES(DLY), .ACK_CHECK(1'b1)) u2 (.clk(clk), .reset(reset), .bus(b2));

  logic [15:0] rom [0:255];
  logic        start_r = 1'b0;
  int          sel = 0;
  int          nack_byte = -1;
  logic        slave_low = 1'b0;
  logic        scl_m, oe_m, busy_m, done_m, nack_m, sda_line;
  logic [7:0]  wc_m, addr_m;

  // Synchronous ROMs with one cycle of read latency.
  always @(posedge clk) begin
    b0.rom_data <= rom[b0.rom_addr];
    b1.rom_data <= rom[b1.rom_addr];
    b2.rom_data <= rom[{6'd0, b2.rom_addr}];
  end

  always_comb begin
    case (sel)
      1: begin
        scl_m = b1.scl_o; oe_m = b1.sda_oe; busy_m = b1.busy; done_m = b1.done;
        nack_m = b1.nack_err; wc_m = b1.write_count; addr_m = b1.rom_addr;
      end
      2: begin
        scl_m = b2.scl_o; oe_m = b2.sda_oe; busy_m = b2.busy; done_m = b2.done;
        nack_m = b2.nack_err; wc_m = {6'd0, b2.write_count}; addr_m = {6'd0, b2.rom_addr};
      end
      default: begin
        scl_m = b0.scl_o; oe_m = b0.sda_oe; busy_m = b0.busy; done_m = b0.done;
        nack_m = b0.nack_err; wc_m = b0.write_count; addr_m = b0.rom_addr;
      end
    endcase
  end

  assign sda_line = !(oe_m || slave_low);
  assign b0.sda_i = (sel == 0) ? sda_line : 1'b1;
  assign b1.sda_i = (sel == 1) ? sda_line : 1'b1;
  assign b2.sda_i = (sel == 2) ? sda_line : 1'b1;
  assign b0.start = start_r && (sel == 0);
  assign b1.start = start_r && (sel == 1);
  assign b2.start = start_r && (sel == 2);

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [7:0] obs_q[$];
  logic [7:0] exp_q[$];
  int         t_fall_q[$];
  int         t_rise_q[$];
  int         n_done = 0, bits_in = 0, byte_idx = 0;
  logic       mon_clr = 1'b0;

  // SCCB slave and bus decoder: START/STOP = SDA edge while SCL stays high.
  initial begin : monitor
    logic       line;
    logic       prev_scl;
    logic       prev_sda;
    logic [7:0] sh;
    prev_scl = 1'b1;
    prev_sda = 1'b1;
    sh = 8'd0;
    forever begin
      @(negedge clk);
      line = !(oe_m || slave_low);
      if (mon_clr) begin
        obs_q.delete(); t_fall_q.delete(); t_rise_q.delete();
        n_done = 0; bits_in = 0; byte_idx = 0; slave_low = 1'b0; line = !oe_m;
      end else begin
        if (scl_m && prev_scl && (line != prev_sda)) begin
          if (!line) begin t_fall_q.push_back(cyc); byte_idx = 0; end
          else t_rise_q.push_back(cyc);
          bits_in = 0;
        end else if (scl_m && !prev_scl) begin
          if (bits_in < 8) begin
            sh = {sh[6:0], line};
            bits_in++;
            if (bits_in == 8) obs_q.push_back(sh);
          end else bits_in = 9;
        end else if (!scl_m && prev_scl) begin
          if (bits_in == 8) slave_low = (byte_idx != nack_byte);
          else if (bits_in == 9) begin slave_low = 1'b0; bits_in = 0; byte_idx++; end
        end
        if (done_m) n_done++;
      end
      prev_scl = scl_m;
      prev_sda = line;
    end
  end

  int checks = 0, errors = 0;
  int start_cyc, first_plain, nwr;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: one write per table entry until END, skipping delays, capped at depth.
  task automatic build_expect(input int depth, output int n);
    exp_q.delete();
    n = 0;
    for (int i = 0; i < depth; i++) begin
      if (rom[i] == END_W) break;
      if (rom[i] != DLY_WD) begin
        exp_q.push_back(DEV);
        exp_q.push_back(rom[i][15:8]);
        exp_q.push_back(rom[i][7:0]);
        n++;
      end
    end
  endtask

  task automatic check_bytes(input string tag);
    check({tag, "_nbytes"}, obs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      check($sformatf("%s_byte%0d", tag, i), obs_q[i], exp_q[i]);
  endtask

  task automatic clear_mon();
    @(posedge clk); mon_clr = 1'b1;
    @(posedge clk); mon_clr = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk); start_r = 1'b1;
    @(negedge clk); start_r = 1'b0;
    start_cyc = cyc;
  endtask

  task automatic wait_run(input string tag);
    int n;
    n = 0;
    while (busy_m && n < 6000) begin @(negedge clk); n++; end
    check({tag, "_timeout"}, (n < 6000), 1);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = END_W;
    repeat (3) @(negedge clk);
    check("rst_scl", scl_m, 1);
    check("rst_sda_oe", oe_m, 0);
    check("rst_busy", busy_m, 0);
    check("rst_done", done_m, 0);
    check("rst_nack", nack_m, 0);
    check("rst_addr", addr_m, 0);
    check("rst_wc", wc_m, 0);
    reset = 1'b0;

    // Two-entry table with END marker.
    rom[0] = 16'h1280; rom[1] = 16'h1100; rom[2] = END_W;
    clear_mon(); pulse_start(); wait_run("t1");
    build_expect(256, nwr);
    check_bytes("t1");
    check("t1_done", n_done, 1);
    check("t1_wc", wc_m, nwr);
    check("t1_nack", nack_m, 0);
    check("t1_sda_falls_scl_high", t_fall_q.size(), 2);
    check("t1_sda_rises_scl_high", t_rise_q.size(), 2);
    // START fall sits one quarter into the frame; frames are 117 quarters + FETCH + DECODE apart.
    check("t1_frame_period", t_fall_q[1] - t_fall_q[0], 117 * CLK_DIV + 2);
    check("t1_start_to_stop", t_rise_q[0] - t_fall_q[0], (1 + 27 * 4 + 2) * CLK_DIV);
    first_plain = t_fall_q[0] - start_cyc;

    // Leading delay marker.
    rom[0] = DLY_WD; rom[1] = 16'h1280; rom[2] = END_W;
    clear_mon(); pulse_start(); wait_run("t2");
    build_expect(256, nwr);
    check_bytes("t2");
    check("t2_delay_min", ((t_fall_q[0] - start_cyc) >= DLY), 1);
    check("t2_delay_extra", (t_fall_q[0] - start_cyc) - first_plain, DLY + 2);
    check("t2_wc", wc_m, 1);

    // NACK on the register address byte with ACK checking enabled.
    rom[0] = 16'h1280; rom[1] = END_W;
    nack_byte = 1;
    clear_mon(); pulse_start(); wait_run("t3");
    build_expect(256, nwr);
    while (exp_q.size() > 2) void'(exp_q.pop_back());
    check_bytes("t3");
    check("t3_stop_seen", t_rise_q.size(), 1);
    check("t3_nack", nack_m, 1);
    check("t3_no_done", n_done, 0);
    check("t3_busy", busy_m, 0);
    check("t3_wc", wc_m, 0);

    // Same NACK with ACK checking disabled.
    sel = 1;
    clear_mon(); pulse_start(); wait_run("t4");
    build_expect(256, nwr);
    check_bytes("t4");
    check("t4_done", n_done, 1);
    check("t4_nack", nack_m, 0);
    check("t4_wc", wc_m, nwr);
    nack_byte = -1;

    // Reset while the data byte's bit 3 is on the bus, then restart.
    sel = 0;
    rom[0] = 16'h1280; rom[1] = 16'h1100; rom[2] = END_W;
    clear_mon(); pulse_start();
    begin
      int n;
      n = 0;
      while (!(byte_idx == 2 && bits_in == 4) && n < 3000) begin @(negedge clk); n++; end
      while (scl_m && n < 3000) begin @(negedge clk); n++; end
      check("t5_reach_bit3", (n < 3000), 1);
    end
    check("t5_pre_oe", oe_m, 1);
    reset = 1'b1;
    #1;
    check("t5_rst_sda_oe", oe_m, 0);
    check("t5_rst_scl", scl_m, 1);
    check("t5_rst_busy", busy_m, 0);
    @(negedge clk); reset = 1'b0;
    clear_mon(); pulse_start();
    check("t5_restart_addr", addr_m, 0);
    check("t5_restart_busy", busy_m, 1);
    wait_run("t5");
    build_expect(256, nwr);
    check_bytes("t5");
    check("t5_wc", wc_m, nwr);

    // Four-entry table with no END marker, plus a start while busy.
    sel = 2;
    for (int i = 0; i < 4; i++) rom[i] = {8'($urandom_range(0, 239)), 8'($urandom)};
    clear_mon(); pulse_start();
    begin
      int n;
      n = 0;
      while (t_rise_q.size() < 1 && n < 3000) begin @(negedge clk); n++; end
      check("t6_first_stop", (n < 3000), 1);
    end
    pulse_start();
    wait_run("t6");
    build_expect(4, nwr);
    check_bytes("t6");
    check("t6_frames", t_rise_q.size(), 4);
    check("t6_done", n_done, 1);
    check("t6_wc", wc_m, nwr % 4);

    // Randomized tables against the reference model.
    sel = 0;
    for (int it = 0; it < 2; it++) begin
      int n;
      n = $urandom_range(2, 4);
      for (int i = 0; i < n; i++) rom[i] = {8'($urandom_range(0, 239)), 8'($urandom)};
      if ($urandom_range(0, 1) == 1) rom[$urandom_range(0, n - 1)] = DLY_WD;
      rom[n] = END_W;
      clear_mon(); pulse_start(); wait_run($sformatf("r%0d", it));
      build_expect(256, nwr);
      check_bytes($sformatf("r%0d", it));
      check($sformatf("r%0d_wc", it), wc_m, nwr);
      check($sformatf("r%0d_done", it), n_done, 1);
      check($sformatf("r%0d_nack", it), nack_m, 0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
